world_transformer: RTL and testbench
====================================

WORLD_TRANSFORMER -- requirements
Module: world_transformer

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the shared packages.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents a job.
REQ-005 in_ready  output  1  block accepts a job this cycle.
REQ-006 in_job  input  model_world_t  model_tri (3 vertices x 3 q16_16_t), model_mtx (matrix_t), model_pos (vec3_t translation), camera_mtx (matrix_t), camera_pos (vec3_t).
REQ-007 out_valid  output  1  result held on out_job.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_job  output  world_camera_t  world_tri (triangle_t), camera_mtx, camera_pos.

Function
REQ-010 SHALL compute world_tri.v[i].c[r] = dot3(model_mtx row r, model_tri.v[i]) + model_pos.c[r] for i,r in 0..2.
REQ-011 dot3 SHALL match dot3_transform: truncate each operand to bits [31:4], form signed 56-bit products, sum at 56 bits, arithmetic-shift right by 8, keep the low 32 bits.
REQ-012 Translation add SHALL be 32-bit two's-complement with wrap and no saturation.
REQ-013 SHALL use exactly one dot3 datapath, time-multiplexed, with one element per cycle.
REQ-014 FSM states: IDLE, COMPUTE, OUT.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, register in_job, set idx=0, go to COMPUTE.
REQ-016 COMPUTE: in_ready=0; each cycle write element idx, where vertex=idx/3 and row=idx%3; idx increments 0..8; at idx=8 go to OUT.
REQ-017 Latency: out_valid SHALL rise after the 9th rising edge following the accepting edge.
REQ-018 OUT: out_valid=1; out_job stable; camera_mtx and camera_pos are the captured input copies; on out_ready go to IDLE.
REQ-019 in_ready SHALL be 0 in COMPUTE and OUT, so no job is accepted in the same cycle as an output handshake; throughput is 1 job per 11 cycles at best.
REQ-020 in_valid while not in IDLE SHALL be ignored; upstream holds its data.
REQ-021 out_ready while not in OUT SHALL be ignored.
REQ-022 out_job SHALL not change while out_valid=1.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, idx=0, out_valid=0, out_job=0, and the captured job=0.
REQ-024 After deassertion, in_ready SHALL be 1 in the first cycle.
REQ-025 Reset mid-COMPUTE or mid-OUT SHALL discard the job with no partial output.

Structure
REQ-026 q16_16_t, vec3_t and triangle_t SHALL live in math_pkg.
REQ-027 matrix_t, model_world_t, world_camera_t and dot3_transform SHALL live in transformer_pkg.
REQ-028 No sub-module; dot3 SHALL be the package function instantiated once.

Verification
REQ-029 Identity model_mtx, model_pos=0, vertices (0x00010000,0x00020000,0x00030000) x3 -> world_tri equals the input; out_valid 9 cycles after acceptance.
REQ-030 model_mtx=diag(0x00020000), model_pos=(0x00010000,0,0xFFFF0000), vertex (0x00010000,0x00010000,0x00010000) -> (0x00030000,0x00020000,0x00010000).
REQ-031 Rounding: R11=0x00010000, vertex x=0x0000000F, other terms 0 -> x result 0x00000000; R11=0xFFFF0000, x=0x00008000 -> 0xFFFF8000.
REQ-032 Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid=1, out_job bit-stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 Reset at COMPUTE idx=4 -> out_valid=0 and out_job=0 immediately; in_ready=1 the first cycle after release; the next job computes correctly.
REQ-034 Back-to-back: in_valid held high with two jobs, out_ready=1 -> two correct results in order, acceptances 11 cycles apart.

Source files
------------

// File: rtl/math_pkg.sv
// Shared fixed-point math types: Q16.16 scalars, 3-vectors and triangles.
package math_pkg;

    typedef logic signed [31:0] q16_16_t;

    typedef struct packed {
        q16_16_t [2:0] c;
    } vec3_t;

    typedef struct packed {
        vec3_t [2:0] v;
    } triangle_t;

endpackage

// File: rtl/transformer_pkg.sv
// Matrix and job types for the model-to-world transform, plus the shared dot3 arithmetic.
package transformer_pkg;
    import math_pkg::*;

    typedef struct packed {
        vec3_t [2:0] r;
    } matrix_t;

    typedef struct packed {
        triangle_t model_tri;
        matrix_t   model_mtx;
        vec3_t     model_pos;
        matrix_t   camera_mtx;
        vec3_t     camera_pos;
    } model_world_t;

    typedef struct packed {
        triangle_t world_tri;
        matrix_t   camera_mtx;
        vec3_t     camera_pos;
    } world_camera_t;

    // Operands drop their 4 LSBs so each product fits 56 bits; the >>>8 restores Q16.16 scale.
    function automatic q16_16_t dot3_transform(input vec3_t a, input vec3_t b);
        logic signed [55:0] acc;
        logic signed [27:0] ta;
        logic signed [27:0] tb;
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            ta  = a.c[k][31:4];
            tb  = b.c[k][31:4];
            acc = acc + 56'(ta) * 56'(tb);
        end
        return q16_16_t'(acc >>> 8);
    endfunction

endpackage

// File: rtl/world_transformer.sv
// Transforms one model-space triangle into world space using a single shared dot3
// datapath, producing one of the nine result elements per cycle.
module world_transformer
    import math_pkg::*;
    import transformer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  model_world_t  in_job,
    output logic          out_valid,
    input  logic          out_ready,
    output world_camera_t out_job
);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUT
    } state_t;

    state_t       state;
    logic [3:0]   idx;
    logic [1:0]   vert;
    logic [1:0]   row;
    model_world_t job_q;
    triangle_t    tri_q;

    vec3_t   cur_row;
    vec3_t   cur_vtx;
    q16_16_t dot_val;
    q16_16_t elem_val;

    always_comb begin
        cur_row  = job_q.model_mtx.r[row];
        cur_vtx  = job_q.model_tri.v[vert];
        dot_val  = dot3_transform(cur_row, cur_vtx);
        elem_val = dot_val + job_q.model_pos.c[row];
    end

    // vert and row track idx/3 and idx%3 incrementally so no divider is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            vert      <= '0;
            row       <= '0;
            job_q     <= '0;
            tri_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        job_q    <= in_job;
                        idx      <= '0;
                        vert     <= '0;
                        row      <= '0;
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    tri_q.v[vert].c[row] <= elem_val;
                    if (idx == 4'd8) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        idx <= idx + 4'd1;
                        if (row == 2'd2) begin
                            row  <= 2'd0;
                            vert <= vert + 2'd1;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_job = {tri_q, job_q.camera_mtx, job_q.camera_pos};

endmodule

// File: tb/tb_world_transformer.sv
// Directed, table-driven bench for world_transformer with hand-computed expected triangles.
module tb_world_transformer;
    import math_pkg::*;
    import transformer_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    model_world_t  in_job;
    logic          out_valid;
    logic          out_ready;
    world_camera_t out_job;

    int total = 0;
    int bad   = 0;

    typedef struct {
        model_world_t job;
        triangle_t    exp_tri;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    world_transformer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_job    (in_job),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_job   (out_job)
    );

    function automatic vec3_t mk_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        vec3_t v;
        v.c[0] = x;
        v.c[1] = y;
        v.c[2] = z;
        return v;
    endfunction

    function automatic triangle_t mk_tri(input vec3_t a, input vec3_t b, input vec3_t c);
        triangle_t t;
        t.v[0] = a;
        t.v[1] = b;
        t.v[2] = c;
        return t;
    endfunction

    function automatic matrix_t mk_mtx(input vec3_t a, input vec3_t b, input vec3_t c);
        matrix_t m;
        m.r[0] = a;
        m.r[1] = b;
        m.r[2] = c;
        return m;
    endfunction

    function automatic model_world_t mk_job(input int n, input triangle_t t, input matrix_t m, input vec3_t p);
        model_world_t j;
        j.model_tri  = t;
        j.model_mtx  = m;
        j.model_pos  = p;
        j.camera_mtx = mk_mtx(mk_vec(32'hCA000000 + 32'(n), 32'h11111111, 32'h22222222),
                              mk_vec(32'h33333333, 32'hCB000000 + 32'(n), 32'h44444444),
                              mk_vec(32'h55555555, 32'h66666666, 32'hCC000000 + 32'(n)));
        j.camera_pos = mk_vec(32'hC0FFEE00 + 32'(n), 32'hBEEF0000, 32'h0000FACE);
        return j;
    endfunction

    task automatic check_output(input string name, input logic [287:0] act, input logic [287:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents vector n, waits for acceptance and for out_valid; leaves out_ready low.
    task automatic apply_stimulus(input int n);
        int cnt;
        @(negedge clk);
        in_job   = vecs[n].job;
        in_valid = 1'b1;
        check_output($sformatf("v%0d_in_ready_idle", n), 288'(in_ready), 288'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check_output($sformatf("v%0d_in_ready_busy", n), 288'(in_ready), 288'(0));
        check_output($sformatf("v%0d_out_valid_early", n), 288'(out_valid), 288'(0));
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_output($sformatf("v%0d_latency", n), 288'(cnt), 288'(9));
        check_output($sformatf("v%0d_world_tri", n), out_job.world_tri, vecs[n].exp_tri);
        check_output($sformatf("v%0d_camera_mtx", n), out_job.camera_mtx, vecs[n].job.camera_mtx);
        check_output($sformatf("v%0d_camera_pos", n), 288'(out_job.camera_pos), 288'(vecs[n].job.camera_pos));
    endtask

    task automatic release_output(input int n);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output($sformatf("v%0d_out_valid_drop", n), 288'(out_valid), 288'(0));
        check_output($sformatf("v%0d_in_ready_back", n), 288'(in_ready), 288'(1));
    endtask

    task automatic back_to_back();
        int cyc;
        int acc1;
        int nres;
        cyc  = 0;
        acc1 = -1;
        nres = 0;
        @(negedge clk);
        in_job    = vecs[0].job;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_output("b2b_ready_first", 288'(in_ready), 288'(1));
        while (nres < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) in_job = vecs[5].job;
            if (out_valid) begin
                check_output($sformatf("b2b_result%0d", nres), out_job.world_tri,
                             (nres == 0) ? vecs[0].exp_tri : vecs[5].exp_tri);
                nres++;
            end
            if (in_ready && acc1 < 0 && cyc > 1) acc1 = cyc;
            if (acc1 >= 0 && cyc == acc1 + 1) in_valid = 1'b0;
        end
        check_output("b2b_result_count", 288'(nres), 288'(2));
        check_output("b2b_accept_gap", 288'(acc1), 288'(11));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        vec3_t zero;
        matrix_t ident;
        zero  = mk_vec(32'h0, 32'h0, 32'h0);
        ident = mk_mtx(mk_vec(32'h00010000, 32'h0, 32'h0),
                       mk_vec(32'h0, 32'h00010000, 32'h0),
                       mk_vec(32'h0, 32'h0, 32'h00010000));

        // identity transform returns the vertices unchanged
        vecs[0].job = mk_job(0,
            mk_tri(mk_vec(32'h00010000, 32'h00020000, 32'h00030000),
                   mk_vec(32'h00010000, 32'h00020000, 32'h00030000),
                   mk_vec(32'h00010000, 32'h00020000, 32'h00030000)),
            ident, zero);
        vecs[0].exp_tri = vecs[0].job.model_tri;

        // scale by 2 then translate by (1,0,-1)
        vecs[1].job = mk_job(1,
            mk_tri(mk_vec(32'h00010000, 32'h00010000, 32'h00010000),
                   mk_vec(32'h00010000, 32'h00010000, 32'h00010000),
                   mk_vec(32'h00010000, 32'h00010000, 32'h00010000)),
            mk_mtx(mk_vec(32'h00020000, 32'h0, 32'h0),
                   mk_vec(32'h0, 32'h00020000, 32'h0),
                   mk_vec(32'h0, 32'h0, 32'h00020000)),
            mk_vec(32'h00010000, 32'h0, 32'hFFFF0000));
        vecs[1].exp_tri = mk_tri(mk_vec(32'h00030000, 32'h00020000, 32'h00010000),
                                 mk_vec(32'h00030000, 32'h00020000, 32'h00010000),
                                 mk_vec(32'h00030000, 32'h00020000, 32'h00010000));

        // low operand bits are truncated away before the multiply
        vecs[2].job = mk_job(2,
            mk_tri(mk_vec(32'h0000000F, 32'h0, 32'h0),
                   mk_vec(32'h00020000, 32'h00001234, 32'h0),
                   mk_vec(32'h00008010, 32'h0, 32'h00070000)),
            mk_mtx(mk_vec(32'h00010000, 32'h0, 32'h0), zero, zero),
            zero);
        vecs[2].exp_tri = mk_tri(mk_vec(32'h0, 32'h0, 32'h0),
                                 mk_vec(32'h00020000, 32'h0, 32'h0),
                                 mk_vec(32'h00008010, 32'h0, 32'h0));

        // negative coefficient with fractional input, plus a large translation
        vecs[3].job = mk_job(3,
            mk_tri(mk_vec(32'h00008000, 32'h0, 32'h0),
                   mk_vec(32'h00010000, 32'h0, 32'h0),
                   zero),
            mk_mtx(mk_vec(32'hFFFF0000, 32'h0, 32'h0), zero, zero),
            mk_vec(32'h0, 32'h7FFFFFFF, 32'h0));
        vecs[3].exp_tri = mk_tri(mk_vec(32'hFFFF8000, 32'h7FFFFFFF, 32'h0),
                                 mk_vec(32'hFFFF0000, 32'h7FFFFFFF, 32'h0),
                                 mk_vec(32'h0, 32'h7FFFFFFF, 32'h0));

        // translation add wraps without saturating
        vecs[4].job = mk_job(4,
            mk_tri(mk_vec(32'h00020000, 32'h0, 32'h0), zero, zero),
            ident, mk_vec(32'h7FFF0000, 32'h0, 32'h0));
        vecs[4].exp_tri = mk_tri(mk_vec(32'h80010000, 32'h0, 32'h0),
                                 mk_vec(32'h7FFF0000, 32'h0, 32'h0),
                                 mk_vec(32'h7FFF0000, 32'h0, 32'h0));

        // mixed matrix with distinct vertices, exposes vertex/row ordering
        vecs[5].job = mk_job(5,
            mk_tri(mk_vec(32'h00020000, 32'h00010000, 32'h00040000),
                   zero,
                   mk_vec(32'h0, 32'h0, 32'h00010000)),
            mk_mtx(mk_vec(32'h00010000, 32'h00020000, 32'h0),
                   mk_vec(32'h0, 32'hFFFF0000, 32'h00008000),
                   mk_vec(32'h00030000, 32'h0, 32'h00010000)),
            mk_vec(32'h00000100, 32'h0, 32'hFFFFFFFF));
        vecs[5].exp_tri = mk_tri(mk_vec(32'h00040100, 32'h00010000, 32'h0009FFFF),
                                 mk_vec(32'h00000100, 32'h0, 32'hFFFFFFFF),
                                 mk_vec(32'h00000100, 32'h00008000, 32'h0000FFFF));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_job    = '0;
        repeat (2) @(negedge clk);
        check_output("reset_out_valid", 288'(out_valid), 288'(0));
        check_output("reset_world_tri", out_job.world_tri, 288'(0));
        check_output("reset_camera_mtx", out_job.camera_mtx, 288'(0));
        rst_n = 1'b1;
        #1;
        check_output("reset_in_ready", 288'(in_ready), 288'(1));

        for (int n = 0; n < 6; n++) begin
            apply_stimulus(n);
            release_output(n);
        end

        $display("[TB] backpressure sequence");
        apply_stimulus(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output($sformatf("bp_out_valid_%0d", k), 288'(out_valid), 288'(1));
            check_output($sformatf("bp_in_ready_%0d", k), 288'(in_ready), 288'(0));
            check_output($sformatf("bp_world_tri_%0d", k), out_job.world_tri, vecs[1].exp_tri);
            check_output($sformatf("bp_camera_pos_%0d", k), 288'(out_job.camera_pos), 288'(vecs[1].job.camera_pos));
        end
        release_output(1);

        $display("[TB] reset during compute");
        @(negedge clk);
        in_job   = vecs[5].job;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_out_valid", 288'(out_valid), 288'(0));
        check_output("mid_rst_world_tri", out_job.world_tri, 288'(0));
        check_output("mid_rst_camera_mtx", out_job.camera_mtx, 288'(0));
        check_output("mid_rst_camera_pos", 288'(out_job.camera_pos), 288'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("post_rst_in_ready", 288'(in_ready), 288'(1));
        repeat (3) @(negedge clk);
        check_output("post_rst_no_output", 288'(out_valid), 288'(0));
        apply_stimulus(5);
        release_output(5);

        $display("[TB] back-to-back sequence");
        back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
